serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 43 ++++
 rtl/serial_subtractor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
// Operand/result handshake bundle for serial_subtractor.
//   din_a, din_b, din_bi : minuend, subtrahend, borrow in
//   din_vld / din_rd     : operand valid / ready
//   dout_d, dout_bo      : difference, borrow out
//   dout_vld / dout_rd   : result valid / ready
//   dout_ov              : signed overflow flag, only when
//                          SERIAL_SUBTRACTOR_OVERFLOW_EN is defined
// Modports: slave (the subtractor), master (the operand source / result sink).
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] din_b;
    logic                  din_bi;
    logic                  din_vld;
    logic                  din_rd;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  dout_bo;
    logic                  dout_vld;
    logic                  dout_rd;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic                  dout_ov;
`endif

    modport slave (
        input  din_a, din_b, din_bi, din_vld, dout_rd,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        output dout_ov,
`endif
        output din_rd, dout_d, dout_bo, dout_vld
    );

    modport master (
        output din_a, din_b, din_bi, din_vld, dout_rd,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        input  dout_ov,
`endif
        input  din_rd, dout_d, dout_bo, dout_vld
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial word subtractor: d = a - b - bi, one bit per clock, LSB first,
// using a single full-subtractor cell and a registered borrow.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   io_sub : serial_subtractor_if.slave (operand and result handshakes)
// Optional feature: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add dout_ov, the
// two's-complement overflow flag of the subtraction.
// Timing: operand accepted at edge 0, dout_vld high after edge DATA_WIDTH;
// minimum initiation interval DATA_WIDTH+2 cycles.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    io_sub
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_d;
    logic                  r_br;
    logic [CNT_W-1:0]      r_cnt;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic                  r_ov;
`endif

    logic [1:0]            w_cell;
    logic                  w_diff;
    logic                  w_borrow;
    logic                  w_last;
    logic [DATA_WIDTH:0]   w_d_shift;
    logic                  w_din_rd;
    logic                  w_dout_vld;

    // One full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    assign w_cell   = full_sub(r_a[0], r_b[0], r_br);
    assign w_diff   = w_cell[0];
    assign w_borrow = w_cell[1];
    assign w_last   = (r_cnt == LAST_BIT);
    // New difference bit enters at the MSB; formed this way so DATA_WIDTH=1 works.
    assign w_d_shift = {w_diff, r_d};

    always_comb begin
        w_state_nxt = r_state;
        w_din_rd    = 1'b0;
        w_dout_vld  = 1'b0;
        case (r_state)
            IDLE: begin
                w_din_rd = 1'b1;
                if (io_sub.din_vld) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_dout_vld = 1'b1;
                if (io_sub.dout_rd) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            r_ov  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_sub.din_vld) begin
                        r_a   <= io_sub.din_a;
                        r_b   <= io_sub.din_b;
                        r_br  <= io_sub.din_bi;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_d   <= w_d_shift[DATA_WIDTH:1];
                    r_br  <= w_borrow;
                    r_cnt <= r_cnt + 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // At the MSB step r_a[0]/r_b[0] are the operand sign bits.
                    if (w_last) r_ov <= (r_a[0] != r_b[0]) && (w_diff != r_a[0]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign io_sub.din_rd   = w_din_rd;
    assign io_sub.dout_vld = w_dout_vld;
    assign io_sub.dout_d   = r_d;
    // After the last bit the borrow register holds the final borrow out and
    // is frozen until a new operand is loaded.
    assign io_sub.dout_bo  = r_br;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign io_sub.dout_ov  = r_ov;
`endif
endmodule
